// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp sequencer and its serial output stage.
package lamp_pkg;

  localparam int unsigned LAMP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } ser_state_t;

endpackage

// File: rtl/lamp_shift_out_if.sv
// Lamp vector in, 74HC595-style serial chain signals out.
interface lamp_shift_out_if
  import lamp_pkg::*;
#(
  parameter int unsigned WIDTH = LAMP_WIDTH
);

  logic [WIDTH-1:0] lamps_i;
  logic             ser_clk;
  logic             ser_data;
  logic             ser_latch;
  logic             busy;
  logic             done;

  modport master (
    output lamps_i,
    input  ser_clk, ser_data, ser_latch, busy, done
  );

  modport slave (
    input  lamps_i,
    output ser_clk, ser_data, ser_latch, busy, done
  );

endinterface

// File: rtl/half_period_tick.sv
// Emits a tick every CLK_DIV cycles; held at zero while restart is high.
module half_period_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_c = (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/lamp_shift_out.sv
// Ships the lamp vector to an external shift-register chain whenever it changes,
// then strobes the latch so the whole pattern updates at once.
module lamp_shift_out
  import lamp_pkg::*;
#(
  parameter int unsigned WIDTH     = LAMP_WIDTH,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  lamp_shift_out_if.slave  bus
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_adv;
  logic             pending_q, pending_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic             tick_c;
  logic             start;
  logic             last_bit;
  logic             ser_clk_q, ser_clk_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_latch_q, ser_latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Each non-idle state lasts exactly CLK_DIV cycles; the counter is parked in IDLE.
  half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state_q == IDLE),
    .tick_c  (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    shreg_d    = shreg_q;
    pending_d  = pending_q;
    bit_d      = bit_q;
    ser_data_d = ser_data_q;
    done_d     = 1'b0;
    start      = pending_q || (bus.lamps_i != shadow_q);
    shreg_adv  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    last_bit   = ((bit_q + BCW'(1)) == BCW'(WIDTH));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT_LO;
          shreg_d    = bus.lamps_i;
          shadow_d   = bus.lamps_i;
          pending_d  = 1'b0;
          bit_d      = '0;
          ser_data_d = head_bit(bus.lamps_i);
        end
      end
      SHIFT_LO: begin
        if (tick_c) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick_c) begin
          shreg_d = shreg_adv;
          bit_d   = bit_q + BCW'(1);
          if (last_bit) begin
            state_d = LATCH;
          end else begin
            state_d    = SHIFT_LO;
            ser_data_d = head_bit(shreg_adv);
          end
        end
      end
      LATCH: begin
        if (tick_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    ser_clk_d   = (state_d == SHIFT_HI);
    ser_latch_d = (state_d == LATCH);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      shreg_q     <= '0;
      pending_q   <= 1'b1;
      bit_q       <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      shreg_q     <= shreg_d;
      pending_q   <= pending_d;
      bit_q       <= bit_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_latch = ser_latch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_lamp_shift_out.sv
// Bench for lamp_shift_out: CLK_DIV=4 and CLK_DIV=1 instances, each feeding a
// reference 595 chain whose latched values are scored against expected frames.
module tb_lamp_shift_out;

  logic clk = 1'b0;
  logic rst4_n = 1'b0;
  logic rst1_n = 1'b0;
  int total = 0;
  int bad = 0;
  int viol = 0;

  always #5 clk = ~clk;

  lamp_shift_out_if #(.WIDTH(16)) bus4 ();
  lamp_shift_out_if #(.WIDTH(16)) bus1 ();

  lamp_shift_out #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bus4.slave));

  lamp_shift_out #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1.slave));

  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_busy(input int i);
    return (i == 0) ? bus4.busy : bus1.busy;
  endfunction

  function automatic logic get_done(input int i);
    return (i == 0) ? bus4.done : bus1.done;
  endfunction

  // Reference 74HC595 chain plus protocol watchers, sampled on the falling edge.
  logic [15:0] sr[2];
  int          edges[2];
  int          since[2];
  int          lh[2];
  logic        pc[2], pl[2], pd[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic rst, sc, sd, sl;
      int   div;
      logic [15:0] expv;
      rst = (i == 0) ? rst4_n : rst1_n;
      sc  = (i == 0) ? bus4.ser_clk : bus1.ser_clk;
      sd  = (i == 0) ? bus4.ser_data : bus1.ser_data;
      sl  = (i == 0) ? bus4.ser_latch : bus1.ser_latch;
      div = (i == 0) ? 4 : 1;
      if (!rst) begin
        edges[i] = 0; since[i] = 0; lh[i] = 0;
        pc[i] = 1'b0; pl[i] = 1'b0; pd[i] = sd;
      end else begin
        if (sc && sl) viol++;
        if (sc && pc[i] && (sd != pd[i])) viol++;
        if (sc && !pc[i]) begin
          edges[i]++;
          sr[i] = {sr[i][14:0], sd};
          since[i] = 0;
        end else begin
          since[i]++;
        end
        if (sl) lh[i]++;
        if (sl && !pl[i]) begin
          chk($sformatf("edges%0d", i), edges[i], 16);
          chk($sformatf("latch_delay%0d", i), since[i], div);
          if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
            chk($sformatf("sb_empty%0d", i), 1, 0);
          end else begin
            expv = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("latched%0d", i), sr[i], expv);
          end
          edges[i] = 0;
        end
        if (!sl && pl[i]) begin
          chk($sformatf("latch_len%0d", i), lh[i], div);
          lh[i] = 0;
        end
        pc[i] = sc; pl[i] = sl; pd[i] = sd;
      end
    end
  end

  task automatic drive(input int i, input logic [15:0] v);
    if (i == 0) begin bus4.lamps_i = v; sb0.push_back(v); end
    else        begin bus1.lamps_i = v; sb1.push_back(v); end
  endtask

  // Counts busy cycles and the done position relative to the start cycle.
  task automatic measure(input int i, input int exp_len);
    int nb, kd;
    nb = 0; kd = 0;
    for (int k = 1; k <= exp_len + 60 && kd == 0; k++) begin
      @(negedge clk);
      if (get_busy(i)) nb++;
      if (get_done(i)) begin
        kd = k;
        chk($sformatf("busy_at_done%0d", i), get_busy(i), 0);
      end
    end
    chk($sformatf("busy_len%0d", i), nb, exp_len);
    chk($sformatf("done_at%0d", i), kd, exp_len + 1);
    @(negedge clk);
    chk($sformatf("done_pulse%0d", i), get_done(i), 0);
  endtask

  task automatic idle_check(input int i, input int n);
    int nb, nr;
    logic p, c;
    nb = 0; nr = 0;
    p = (i == 0) ? bus4.ser_clk : bus1.ser_clk;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c = (i == 0) ? bus4.ser_clk : bus1.ser_clk;
      if (get_busy(i)) nb++;
      if (c && !p) nr++;
      p = c;
    end
    chk($sformatf("idle_busy%0d", i), nb, 0);
    chk($sformatf("idle_sclk%0d", i), nr, 0);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] lamps;
    int          len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int kd;
    vecs[0] = '{0, 16'hA5C3, 132};
    vecs[1] = '{0, 16'hFFFF, 132};
    vecs[2] = '{0, 16'h8001, 132};
    vecs[3] = '{1, 16'h5A3C, 33};
    vecs[4] = '{1, 16'h0001, 33};
    vecs[5] = '{1, 16'h7E81, 33};

    bus4.lamps_i = 16'h0000;
    bus1.lamps_i = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ser_clk", bus4.ser_clk, 0);
    chk("rst_ser_data", bus4.ser_data, 0);
    chk("rst_ser_latch", bus4.ser_latch, 0);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_done", bus4.done, 0);

    // Pending frame after reset even though lamps equal the cleared shadow.
    rst4_n = 1'b1;
    sb0.push_back(16'h0000);
    measure(0, 132);
    rst1_n = 1'b1;
    sb1.push_back(16'h0000);
    measure(1, 33);

    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].inst, vecs[v].lamps);
      measure(vecs[v].inst, vecs[v].len);
    end

    idle_check(0, 500);
    idle_check(1, 20);

    // Mid-frame changes collapse into a single back-to-back frame of the latest value.
    drive(0, 16'h0001);
    sb0.push_back(16'h0007);
    kd = 0;
    for (int k = 1; k <= 300 && kd == 0; k++) begin
      @(negedge clk);
      if (k == 20) bus4.lamps_i = 16'h0003;
      if (k == 40) bus4.lamps_i = 16'h0007;
      if (bus4.done) kd = k;
    end
    chk("chg_done_at", kd, 133);
    measure(0, 132);
    idle_check(0, 100);

    // Reset while bit 7 is in its high phase; the whole frame must be resent.
    drive(0, 16'h13C5);
    repeat (62) @(negedge clk);
    chk("pre_rst_sclk", bus4.ser_clk, 1);
    chk("pre_rst_data", bus4.ser_data, 1);
    #2 rst4_n = 1'b0;
    #1;
    chk("mid_rst_ser_clk", bus4.ser_clk, 0);
    chk("mid_rst_ser_data", bus4.ser_data, 0);
    chk("mid_rst_ser_latch", bus4.ser_latch, 0);
    chk("mid_rst_busy", bus4.busy, 0);
    chk("mid_rst_done", bus4.done, 0);
    repeat (3) @(negedge clk);
    rst4_n = 1'b1;
    measure(0, 132);
    idle_check(0, 50);

    chk("sb0_left", sb0.size(), 0);
    chk("sb1_left", sb1.size(), 0);
    chk("protocol_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lamp_shift_out.md
# lamp_shift_out

Downstream output stage for the `bound_flash` lamp sequencer. It takes the parallel lamp vector and ships it serially to an external chain of 74HC595-style shift-register LED drivers using a serial clock, a data line and a latch strobe. The lamp pattern only needs a few board pins, and the external latch updates all lamps in one step, so no partial pattern is ever displayed. A new frame is sent whenever the lamp vector differs from the last value shipped.

## Interface
- `WIDTH`, 16: number of lamps (serial bits per frame), ≥1.
- `CLK_DIV`, 4: system clocks per serial half-period, ≥1.
- `MSB_FIRST`, 1: 1 sends `lamps_i[WIDTH-1]` first; 0 sends `lamps_i[0]` first.

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `lamps_i`, in, WIDTH: lamp vector from `bound_flash`. It is synchronous to `clk` and may change on any cycle.
- `ser_clk`, out, 1: serial shift clock. The driver samples `ser_data` on the rising edge of `ser_clk`.
- `ser_data`, out, 1: serial data.
- `ser_latch`, out, 1: storage-register strobe. A high pulse transfers the shifted frame to the lamp outputs.
- `busy`, out, 1: high while a frame is in flight.
- `done`, out, 1: one-cycle pulse after each completed frame.

## Operation
- Internal registers:
  - `shadow`, WIDTH bits: last value shipped.
  - `pending`: set at reset.
  - `shreg`, WIDTH bits.
  - Half-period counter, `$clog2(CLK_DIV)` bits, minimum 1.
  - Bit counter, `$clog2(WIDTH+1)` bits.
- Start condition, evaluated only in IDLE: `pending` is 1, or `lamps_i != shadow`.
  - On start: load `shreg` and `shadow` with `lamps_i`, and clear `pending`.
  - The first frame after reset is therefore always sent, regardless of the value of `lamps_i`.
- States:
  - IDLE: `busy`=0. On the start condition, go to SHIFT_LO.
  - SHIFT_LO: `ser_clk`=0 and `ser_data` = current bit. Hold for CLK_DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: `ser_clk`=1 and `ser_data` is held stable. Hold for CLK_DIV cycles, then advance `shreg` and the bit counter.
    - If WIDTH bits have been sent, go to LATCH.
    - Otherwise go to SHIFT_LO.
  - LATCH: `ser_clk`=0 and `ser_latch`=1 for CLK_DIV cycles, then go to IDLE and pulse `done`.
- Changes on `lamps_i` while `busy` are not captured mid-frame.
  - Only the value present on the first IDLE cycle is compared.
  - Intermediate values are dropped; only the latest value is shipped.
- Back-to-back frames: if the start condition holds on the IDLE cycle that carries `done`, the next frame starts from that cycle.
- `ser_data` in IDLE holds the last bit sent (0 after reset).
- Reset mid-frame:
  - All outputs go to their reset values immediately.
  - `pending` is set, so a full frame is resent after `rst_n` rises.

## Timing
- Reset values: `ser_clk`=0, `ser_data`=0, `ser_latch`=0, `busy`=0, `done`=0. State is IDLE and `shadow`=0.
- Start detected in cycle N (IDLE):
  - Cycle N+1: SHIFT_LO, `busy`=1.
  - Frame length is 2·CLK_DIV·WIDTH + CLK_DIV cycles. With the defaults this is 132, so `busy` is high for N+1 … N+132.
  - Cycle N+133: IDLE, `busy`=0, `done`=1.
- `ser_data` changes only on the first SHIFT_LO cycle of each bit. Setup and hold to the `ser_clk` rising edge are each CLK_DIV cycles.
- `ser_latch` rises one full LO period (CLK_DIV cycles) after the last `ser_clk` rising edge. `ser_clk` and `ser_latch` are never both high.
- All outputs are registered; there are no combinational paths from `lamps_i` to the outputs.

## Structure
- Shared package `lamp_pkg` holds:
  - `LAMP_WIDTH` = 16, also used by `bound_flash`.
  - State enum `ser_state_t` {IDLE, SHIFT_LO, SHIFT_HI, LATCH}.
- Sub-module `half_period_tick`: a counter that emits a tick every CLK_DIV cycles and restarts on the state-entry cycle.

## Test plan
- Reset release with `lamps_i`=16'h0000: one frame is sent. There are 16 `ser_clk` rising edges with `ser_data`=0, then `ser_latch` is high for 4 cycles, `done` pulses at cycle 133, and `busy` is then 0.
- `lamps_i`=16'hA5C3 with MSB_FIRST=1: the bits sampled at the `ser_clk` rising edges read 1010_0101_1100_0011. A reference shift register model latches 16'hA5C3.
- `lamps_i` is held constant after the first frame for 500 cycles: `busy` stays 0 and there are no `ser_clk` edges.
- `lamps_i` is changed 16'h0001→16'h0003→16'h0007 during one frame: exactly one further frame starts on the `done` cycle and ships 16'h0007.
- `rst_n` is asserted at bit 7 of a frame: all outputs are 0 in the same cycle. After release, a full 132-cycle frame resends the current `lamps_i`.
- CLK_DIV=1 with WIDTH=16: the frame is 33 cycles, `ser_clk` toggles every cycle, and `done` arrives at N+34.
